// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave backed by a word-addressed register array.
// Serves one write burst (AW/W/B) and one read burst (AR/R) concurrently;
// INCR bursts wrap at the top of the array, FIXED bursts hold one word.
module axi4_mem_responder #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_AW           = 10
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    // write address channel
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]                      s_axi_awlen,
    input  logic [2:0]                      s_axi_awsize,
    input  logic [1:0]                      s_axi_awburst,
    input  logic                            s_axi_awlock,
    input  logic [3:0]                      s_axi_awcache,
    input  logic [2:0]                      s_axi_awprot,
    input  logic [3:0]                      s_axi_awqos,
    input  logic [3:0]                      s_axi_awregion,
    input  logic                            s_axi_awuser,
    // write data channel
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_wid,
    input  logic                            s_axi_wuser,
    // write response channel
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    output logic [1:0]                      s_axi_bresp,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic                            s_axi_buser,
    // read address channel
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]                      s_axi_arlen,
    input  logic [2:0]                      s_axi_arsize,
    input  logic [1:0]                      s_axi_arburst,
    input  logic                            s_axi_arlock,
    input  logic [3:0]                      s_axi_arcache,
    input  logic [2:0]                      s_axi_arprot,
    input  logic [3:0]                      s_axi_arqos,
    input  logic [3:0]                      s_axi_arregion,
    input  logic                            s_axi_aruser,
    // read data channel
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic [1:0]                      s_axi_rresp,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic                            s_axi_ruser
);

    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int DEPTH    = 1 << C_MEM_AW;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Memory array and bookkeeping state
    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                        rst_done_q;
    w_state_e                    w_state_q, w_state_d;
    logic [C_MEM_AW-1:0]         w_idx_q, w_idx_d;
    logic [7:0]                  w_cnt_q, w_cnt_d;
    logic [7:0]                  w_len_q, w_len_d;
    logic                        w_fixed_q, w_fixed_d;
    logic                        w_err_q, w_err_d;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    logic                        w_last_beat;
    logic                        mem_we;

    r_state_e                    r_state_q, r_state_d;
    logic [C_MEM_AW-1:0]         r_idx_q, r_idx_d;
    logic [7:0]                  r_cnt_q, r_cnt_d;
    logic [7:0]                  r_len_q, r_len_d;
    logic                        r_fixed_q, r_fixed_d;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
    logic                        r_last_beat;

    // Sideband fields carry nothing this slave uses; the address buses are
    // only partly decoded (byte offset and upper bits fall away).
    logic unused_ok;
    assign unused_ok = ^{s_axi_awaddr, s_axi_awsize, s_axi_awlock, s_axi_awcache,
                         s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser,
                         s_axi_wid, s_axi_wuser,
                         s_axi_araddr, s_axi_arsize, s_axi_arlock, s_axi_arcache,
                         s_axi_arprot, s_axi_arqos, s_axi_arregion, s_axi_aruser};

    assign s_axi_rresp = 2'b00;
    assign s_axi_ruser = 1'b0;
    assign s_axi_buser = 1'b0;
    assign s_axi_bid   = w_id_q;
    assign s_axi_rid   = r_id_q;

    // State registers for both channels; reset aborts any burst in flight
    always_ff @(posedge ap_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!ap_rst_n) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            w_idx_q    <= '0;
            w_cnt_q    <= '0;
            w_len_q    <= '0;
            w_fixed_q  <= 1'b0;
            w_err_q    <= 1'b0;
            w_id_q     <= '0;
            r_state_q  <= R_IDLE;
            r_idx_q    <= '0;
            r_cnt_q    <= '0;
            r_len_q    <= '0;
            r_fixed_q  <= 1'b0;
            r_id_q     <= '0;
        end else begin
            rst_done_q <= 1'b1;
            w_state_q  <= w_state_d;
            w_idx_q    <= w_idx_d;
            w_cnt_q    <= w_cnt_d;
            w_len_q    <= w_len_d;
            w_fixed_q  <= w_fixed_d;
            w_err_q    <= w_err_d;
            w_id_q     <= w_id_d;
            r_state_q  <= r_state_d;
            r_idx_q    <= r_idx_d;
            r_cnt_q    <= r_cnt_d;
            r_len_q    <= r_len_d;
            r_fixed_q  <= r_fixed_d;
            r_id_q     <= r_id_d;
        end
    end

    // Byte-strobed memory write on each accepted W beat
    always_ff @(posedge ap_clk) begin
        // NOTE: the array has no reset on purpose; contents persist across
        // ap_rst_n and a reset branch would turn it into a huge flop bank.
        if (mem_we && ap_rst_n) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Write FSM: next state, burst bookkeeping and AW/W/B handshake outputs
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_state_d     = w_state_q;
        w_idx_d       = w_idx_q;
        w_cnt_d       = w_cnt_q;
        w_len_d       = w_len_q;
        w_fixed_d     = w_fixed_q;
        w_err_d       = w_err_q;
        w_id_d        = w_id_q;
        w_last_beat   = (w_cnt_q == w_len_q);
        mem_we        = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = 2'b00;
        case (w_state_q)
            W_IDLE: begin
                s_axi_awready = rst_done_q;
                if (s_axi_awvalid && rst_done_q) begin
                    w_idx_d   = s_axi_awaddr[ADDR_LSB +: C_MEM_AW];
                    w_id_d    = s_axi_awid;
                    w_len_d   = s_axi_awlen;
                    w_fixed_d = (s_axi_awburst == 2'b00);
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_we = 1'b1;
                    // The beat count ends the burst; a misplaced or missing
                    // wlast only flags the response.
                    if (s_axi_wlast != w_last_beat) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        if (!w_fixed_q) begin
                            w_idx_d = w_idx_q + 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = w_err_q ? 2'b10 : 2'b00;
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: next state, burst bookkeeping and AR/R handshake outputs
    always_comb begin
        r_state_d     = r_state_q;
        r_idx_d       = r_idx_q;
        r_cnt_d       = r_cnt_q;
        r_len_d       = r_len_q;
        r_fixed_d     = r_fixed_q;
        r_id_d        = r_id_q;
        r_last_beat   = (r_cnt_q == r_len_q);
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_rdata   = '0;
        case (r_state_q)
            R_IDLE: begin
                s_axi_arready = rst_done_q;
                if (s_axi_arvalid && rst_done_q) begin
                    r_idx_d   = s_axi_araddr[ADDR_LSB +: C_MEM_AW];
                    r_id_d    = s_axi_arid;
                    r_len_d   = s_axi_arlen;
                    r_fixed_d = (s_axi_arburst == 2'b00);
                    r_cnt_d   = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = r_last_beat;
                s_axi_rdata  = mem_q[r_idx_q];
                if (s_axi_rready) begin
                    if (r_last_beat) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q + 8'd1;
                        if (!r_fixed_q) begin
                            r_idx_d = r_idx_q + 1'b1;
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: INCR/FIXED/strobe/wrap writes,
// protocol-error responses, read back-pressure with a concurrent write,
// and reset in the middle of a read burst.
module tb_axi4_mem_responder;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [0:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = 2'b01;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic [0:0]  bid;
    logic        buser;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [0:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = 2'b01;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;
    logic [0:0]  rid;
    logic        ruser;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wbuf [8];
    logic [3:0]  sbuf [8];
    logic [31:0] rexp [8];

    always #5 ap_clk = ~ap_clk;

    axi4_mem_responder dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awsize(3'd2),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0),
        .s_axi_awprot(3'd0), .s_axi_awqos(4'd0), .s_axi_awregion(4'd0),
        .s_axi_awuser(1'b0),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wid(1'b0), .s_axi_wuser(1'b0),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_bid(bid), .s_axi_buser(buser),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arsize(3'd2),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0),
        .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_arregion(4'd0),
        .s_axi_aruser(1'b0),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rlast(rlast), .s_axi_rresp(rresp), .s_axi_rid(rid), .s_axi_ruser(ruser)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // One write burst from wbuf/sbuf; wlast on beat lastpos (-1 = never).
    task automatic do_write(input logic [31:0] addr, input logic id, input int len,
                            input logic [1:0] burst, input int lastpos,
                            input logic [1:0] exp_resp);
        int guard = 0;
        awaddr = addr; awid = id; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        while (!awready && guard < 50) begin tick(); guard++; end
        check("aw_ready_wait", 64'(guard < 50), 64'd1);
        tick();
        awvalid = 1'b0;
        check("aw_to_wready", 64'(wready), 64'd1);
        check("aw_awready_low", 64'(awready), 64'd0);
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == lastpos);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_to_bvalid", 64'(bvalid), 64'd1);
        check("w_wready_low", 64'(wready), 64'd0);
        check("bresp", 64'(bresp), 64'(exp_resp));
        check("bid", 64'(bid), 64'(id));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_to_awready", 64'(awready), 64'd1);
        check("b_bvalid_low", 64'(bvalid), 64'd0);
    endtask

    // One read burst checked against rexp; toggle stalls every other cycle.
    task automatic do_read(input logic [31:0] addr, input logic id, input int len,
                           input logic [1:0] burst, input bit toggle);
        int guard = 0;
        int i = 0;
        int cyc = 0;
        araddr = addr; arid = id; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        while (!arready && guard < 50) begin tick(); guard++; end
        check("ar_ready_wait", 64'(guard < 50), 64'd1);
        tick();
        arvalid = 1'b0;
        check("ar_to_rvalid", 64'(rvalid), 64'd1);
        check("ar_arready_low", 64'(arready), 64'd0);
        while (i <= len && cyc < 100) begin
            check("rvalid", 64'(rvalid), 64'd1);
            check("rdata", 64'(rdata), 64'(rexp[i]));
            check("rlast", 64'(rlast), 64'(i == len));
            check("rid", 64'(rid), 64'(id));
            rready = !toggle || (cyc % 2 == 1);
            tick();
            if (rready) i++;
            cyc++;
        end
        rready = 1'b0;
        check("r_burst_done", 64'(i), 64'(len + 1));
        check("r_rvalid_low", 64'(rvalid), 64'd0);
        check("r_to_arready", 64'(arready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        ap_rst_n = 1'b1;
        tick();
        check("rel_awready", 64'(awready), 64'd1);
        check("rel_arready", 64'(arready), 64'd1);

        // INCR write and readback
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        for (int i = 0; i < 8; i++) sbuf[i] = 4'hF;
        do_write(32'h100, 1'b1, 3, 2'b01, 3, 2'b00);
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        do_read(32'h100, 1'b1, 3, 2'b01, 1'b0);

        // strobes with a FIXED burst
        wbuf[0] = 32'hAABBCCDD;
        do_write(32'h0, 1'b0, 0, 2'b01, 0, 2'b00);
        wbuf[0] = 32'h00000011; sbuf[0] = 4'h1;
        wbuf[1] = 32'h00002200; sbuf[1] = 4'h2;
        do_write(32'h0, 1'b0, 1, 2'b00, 1, 2'b00);
        rexp[0] = 32'hAABB2211;
        do_read(32'h0, 1'b0, 0, 2'b01, 1'b0);

        // INCR wrap from the last word to word 0
        for (int i = 0; i < 8; i++) sbuf[i] = 4'hF;
        wbuf[0] = 32'hDEAD0001; wbuf[1] = 32'hDEAD0002;
        do_write(32'hFFC, 1'b1, 1, 2'b01, 1, 2'b00);
        rexp[0] = 32'hDEAD0001; rexp[1] = 32'hDEAD0002;
        do_read(32'hFFC, 1'b1, 1, 2'b01, 1'b0);
        rexp[0] = 32'hDEAD0002;
        do_read(32'h0, 1'b0, 0, 2'b01, 1'b0);

        // wlast early, then wlast never: full length still taken, SLVERR
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5000 + 32'(i);
        do_write(32'h200, 1'b0, 3, 2'b01, 1, 2'b10);
        for (int i = 0; i < 4; i++) rexp[i] = 32'h5000 + 32'(i);
        do_read(32'h200, 1'b0, 3, 2'b01, 1'b0);
        do_write(32'h300, 1'b1, 3, 2'b01, -1, 2'b10);

        // preload, then stalled read running alongside an 8-beat write
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0A0_0000 + 32'(i * 3);
        do_write(32'h400, 1'b0, 7, 2'b01, 7, 2'b00);
        for (int i = 0; i < 8; i++) rexp[i] = 32'hA0A0_0000 + 32'(i * 3);
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hB0B0_0000 + 32'(i * 5);
        fork
            do_read(32'h400, 1'b1, 7, 2'b01, 1'b1);
            do_write(32'h800, 1'b1, 7, 2'b01, 7, 2'b00);
        join
        for (int i = 0; i < 8; i++) rexp[i] = 32'hB0B0_0000 + 32'(i * 5);
        do_read(32'h800, 1'b0, 7, 2'b01, 1'b0);

        // reset after two beats of an 8-beat read
        for (int i = 0; i < 8; i++) rexp[i] = 32'hA0A0_0000 + 32'(i * 3);
        araddr = 32'h400; arid = 1'b0; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        check("mid_rdata_beat2", 64'(rdata), 64'(rexp[2]));
        ap_rst_n = 1'b0;
        tick();
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_rlast", 64'(rlast), 64'd0);
        check("mid_rst_rdata", 64'(rdata), 64'd0);
        check("mid_rst_arready", 64'(arready), 64'd0);
        rready = 1'b0;
        ap_rst_n = 1'b1;
        tick();
        check("mid_rel_arready", 64'(arready), 64'd1);
        check("mid_rel_rvalid", 64'(rvalid), 64'd0);
        do_read(32'h400, 1'b0, 7, 2'b01, 1'b0);
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        do_read(32'h100, 1'b1, 3, 2'b01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

AXI4 slave memory responder that answers the burst read and write transactions issued by the DMA master (read engine on AR/R, write engine on AW/W/B). It holds a word-addressed register-array memory, serves one read burst and one write burst concurrently on independent channels, and is the bus-side endpoint for DMA bring-up benches and small on-chip scratch buffers.

## Interface
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
- C_S_AXI_ADDR_WIDTH, 32, byte address width
- C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64 only
- C_MEM_AW, 10, log2 of memory depth in words (default 1024 words)

- ap_clk  in  1  sole clock; all logic on rising edge
- ap_rst_n  in  1  reset, synchronous, active-low
- s_axi_awvalid/awready  in/out  1  write address handshake
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  burst start byte address
- s_axi_awid  in  C_S_AXI_ID_WIDTH  write ID, echoed on BID
- s_axi_awlen  in  8  beats minus 1
- s_axi_awsize  in  3  ignored; full-width beats only
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10/11 treated as INCR
- s_axi_wvalid/wready  in/out  1  write data handshake
- s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data
- s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat marker
- s_axi_bvalid/bready  out/in  1  write response handshake
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bid  out  C_S_AXI_ID_WIDTH  captured AWID
- s_axi_arvalid/arready  in/out  1  read address handshake
- s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  as AW  read request fields, same rules
- s_axi_rvalid/rready  out/in  1  read data handshake
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data
- s_axi_rlast  out  1  last read beat
- s_axi_rresp  out  2  always 00
- s_axi_rid  out  C_S_AXI_ID_WIDTH  captured ARID
- AWLOCK/CACHE/PROT/QOS/REGION/USER, WID/WUSER, ARLOCK/.../ARUSER inputs accepted and ignored; RUSER/BUSER outputs tied 0

## Operation
- Word index = addr[ADDR_LSB+C_MEM_AW-1:ADDR_LSB], ADDR_LSB = log2(DATA_WIDTH/8); low address bits ignored; index wraps modulo depth (no error).
- INCR: index +1 per beat, wraps 2^C_MEM_AW-1 -> 0. FIXED: index constant for whole burst.
- Write FSM: W_IDLE (awready=1) -> on AW handshake capture index, awid, awlen, burst; clear beat count -> W_DATA (wready=1) -> each W handshake writes bytes with wstrb=1, count++ -> on beat count==awlen go W_RESP (bvalid=1) -> on B handshake W_IDLE.
- Beat count, not wlast, ends the burst. bresp=10 if any beat had wlast != (count==awlen); else 00.
- Read FSM: R_IDLE (arready=1) -> on AR handshake capture index, arid, arlen, burst -> R_DATA (rvalid=1, rdata=mem[index] combinational from array, rlast=(count==arlen)) -> each R handshake advances index/count -> after rlast beat handshake R_IDLE.
- Channels fully independent; read and write may be active the same cycle. Write commits on the W-handshake edge; a read of the same word in the following cycle returns new data.
- Memory content has no reset and survives ap_rst_n.

## Timing
- Reset (ap_rst_n=0 at an edge): awready, wready, bvalid, arready, rvalid, rlast=0; bresp, rresp, bid, rid, rdata=0 visible from that edge; both FSMs to IDLE, aborting any burst mid-flight; no response for aborted bursts.
- First cycle after reset release: awready=arready=1.
- AW handshake at edge N -> awready=0, wready=1 from N+1. Final W beat at edge M -> wready=0, bvalid=1 from M+1. B handshake at edge K -> awready=1 from K+1.
- AR handshake at N -> arready=0, rvalid=1 with beat 0 from N+1. With rready held high, one beat per cycle, no bubbles; burst of L+1 beats occupies N+1..N+L+1; arready=1 from cycle after last handshake.
- rvalid/rdata/rlast/rid held stable while rready=0; bvalid/bresp/bid held while bready=0.
- Single-beat bursts (len=0): rlast=1 on beat 0; B follows one cycle after single W beat.
- Throughput: one write burst per len+3 cycles minimum.

## Test plan
- Write INCR awaddr=0x100, awlen=3, data 0x11..0x44, wstrb=F, wlast on beat 3 -> bvalid 1 cycle after beat 3, bresp=00, bid=awid; read araddr=0x100, arlen=3 -> 0x11,0x22,0x33,0x44, rlast on 4th, rvalid 1 cycle after AR.
- Strobe + FIXED: write 0xAABBCCDD to 0x0, then FIXED awlen=1 at 0x0 with wdata 0x00000011 wstrb=1, then 0x00002200 wstrb=2 -> read 0x0 returns 0xAABB2211.
- Wrap: INCR write awlen=1 at last word ((2^C_MEM_AW-1)*4) -> beat 1 lands at word 0; readback confirms.
- Protocol error: awlen=3 with wlast on beat 1 -> burst still takes 4 beats, bresp=10; separate run with wlast never set -> bresp=10.
- Back-pressure + concurrency: rready toggling 1/0 every cycle during arlen=7 read while an awlen=7 write runs -> 8 correct beats, outputs stable during stalls, both bursts complete.
- Reset mid-burst: assert ap_rst_n=0 after 2 of 8 read beats -> rvalid=0 next edge, arready=1 one cycle after release, earlier-written memory data intact on re-read.
